nios_system_pio_pulse: RTL and testbench



---
 rtl/nios_system_pio_pulse.sv | 143 ++++++++++++++
 tb/tb_nios_system_pio_pulse.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/nios_system_pio_pulse.sv
// Avalon-MM output PIO with atomic set/clear, a one-shot pulse engine and a sticky DONE flag.
// Define NIOS_PIO_PULSE_IRQ_EN to add the IRQEN register at address 6 and drive irq.
module nios_system_pio_pulse #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned PULSE_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  localparam logic [2:0] AddrData   = 3'd0;
  localparam logic [2:0] AddrSet    = 3'd1;
  localparam logic [2:0] AddrClr    = 3'd2;
  localparam logic [2:0] AddrPlen   = 3'd3;
  localparam logic [2:0] AddrPulse  = 3'd4;
  localparam logic [2:0] AddrStatus = 3'd5;
`ifdef NIOS_PIO_PULSE_IRQ_EN
  localparam logic [2:0] AddrIrqen  = 3'd6;
`endif

  typedef enum logic {StIdle, StActive} state_e;

  state_e             r_state, w_state_next;
  logic [WIDTH-1:0]   r_data_out, w_data_out_next;
  logic [WIDTH-1:0]   r_pulse_mask, w_pulse_mask_next;
  logic [PULSE_W-1:0] r_plen, w_plen_next;
  logic [PULSE_W-1:0] r_cnt, w_cnt_next;
  logic               r_done, w_done_next;

  logic               w_wr;
  logic               w_busy;
  logic               w_start;
  logic               w_expire;
  logic [WIDTH-1:0]   w_wd_bits;
  logic [PULSE_W-1:0] w_wd_plen;
  logic               w_unused_wdata;

  assign w_wr      = chipselect & ~write_n;
  assign w_wd_bits = writedata[WIDTH-1:0];
  assign w_wd_plen = writedata[PULSE_W-1:0];
  assign w_busy    = (r_state == StActive);
  // A PULSE write with PLEN=0 is dropped entirely.
  assign w_start   = w_wr && (address == AddrPulse) && (r_plen != '0);
  assign w_expire  = w_busy && (r_cnt == PULSE_W'(1)) && !w_start;
  assign w_unused_wdata = ^writedata;

  always_comb begin
    w_data_out_next = r_data_out;
    w_plen_next     = r_plen;
    if (w_wr) begin
      case (address)
        AddrData: w_data_out_next = w_wd_bits;
        AddrSet:  w_data_out_next = r_data_out | w_wd_bits;
        AddrClr:  w_data_out_next = r_data_out & ~w_wd_bits;
        AddrPlen: w_plen_next     = w_wd_plen;
        default:  ;
      endcase
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_cnt_next        = r_cnt;
    w_pulse_mask_next = r_pulse_mask;
    w_done_next       = r_done;
    case (r_state)
      StIdle: begin
        if (w_start) w_state_next = StActive;
      end
      StActive: begin
        if (w_expire) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
    if (w_start) begin
      w_cnt_next        = r_plen;
      w_pulse_mask_next = w_wd_bits;
    end else if (w_busy) begin
      w_cnt_next = r_cnt - PULSE_W'(1);
    end
    if (w_wr && (address == AddrStatus) && writedata[1]) w_done_next = 1'b0;
    // Hardware set overrides a simultaneous software clear.
    if (w_expire) w_done_next = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= StIdle;
      r_data_out   <= '0;
      r_pulse_mask <= '0;
      r_plen       <= '0;
      r_cnt        <= '0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_data_out   <= w_data_out_next;
      r_pulse_mask <= w_pulse_mask_next;
      r_plen       <= w_plen_next;
      r_cnt        <= w_cnt_next;
      r_done       <= w_done_next;
    end
  end

`ifdef NIOS_PIO_PULSE_IRQ_EN
  logic r_irqen;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irqen <= 1'b0;
    end else if (w_wr && (address == AddrIrqen)) begin
      r_irqen <= writedata[0];
    end
  end

  assign irq = r_done & r_irqen;
`else
  assign irq = 1'b0;
`endif

  assign out_port = r_data_out ^ (w_busy ? r_pulse_mask : '0);

  always_comb begin
    readdata = '0;
    case (address)
      AddrData:   readdata[WIDTH-1:0]   = r_data_out;
      AddrPlen:   readdata[PULSE_W-1:0] = r_plen;
      AddrPulse:  readdata[WIDTH-1:0]   = r_pulse_mask;
      AddrStatus: readdata[1:0]         = {r_done, w_busy};
`ifdef NIOS_PIO_PULSE_IRQ_EN
      AddrIrqen:  readdata[0]           = r_irqen;
`endif
      default:    ;
    endcase
  end

endmodule

// File: tb/tb_nios_system_pio_pulse.sv
// Self-checking bench for nios_system_pio_pulse: vector table plus hand-written pulse sequences,
// with expected results queued per step and compared after each clock edge.
module tb_nios_system_pio_pulse;

  localparam int WIDTH   = 8;
  localparam int PULSE_W = 16;
  localparam int NVec    = 32;
`ifdef NIOS_PIO_PULSE_IRQ_EN
  localparam bit IrqOn = 1'b1;
`else
  localparam bit IrqOn = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset_n;
  logic [2:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [31:0]      writedata;
  logic [31:0]      readdata;
  logic [WIDTH-1:0] out_port;
  logic             irq;

  nios_system_pio_pulse #(
    .WIDTH  (WIDTH),
    .PULSE_W(PULSE_W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .out_port  (out_port),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] out;
    logic [31:0]      rd;
    logic             irq;
  } exp_t;

  typedef struct {
    bit               we;
    logic [2:0]       addr;
    logic [31:0]      wd;
    logic [2:0]       rd_addr;
    logic [WIDTH-1:0] exp_out;
    logic [31:0]      exp_rd;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[NVec];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic compare(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, got 0 entries, expected 1", tag);
      return;
    end
    e = sb_q.pop_front();
    check({tag, " out_port"}, 32'(out_port), 32'(e.out));
    check({tag, " readdata"}, readdata, e.rd);
    check({tag, " irq"}, 32'(irq), 32'(e.irq));
  endtask

  // One bus cycle: optional write, then read rd_addr after the edge and compare.
  task automatic step(input bit we, input logic [2:0] addr, input logic [31:0] wd,
                      input logic [2:0] rd_addr, input logic [WIDTH-1:0] exp_out,
                      input logic [31:0] exp_rd, input logic exp_irq, input string tag);
    exp_t e;
    @(negedge clk);
    chipselect = we;
    write_n    = ~we;
    address    = addr;
    writedata  = wd;
    e.out = exp_out;
    e.rd  = exp_rd;
    e.irq = exp_irq;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    chipselect = 1'b1;
    write_n    = 1'b1;
    address    = rd_addr;
    #1;
    compare(tag);
  endtask

  task automatic idle(input logic [2:0] rd_addr, input logic [WIDTH-1:0] exp_out,
                      input logic [31:0] exp_rd, input logic exp_irq, input string tag);
    step(1'b0, 3'd0, 32'd0, rd_addr, exp_out, exp_rd, exp_irq, tag);
  endtask

  initial begin
    exp_t e;
    vecs = '{
      '{1'b1, 3'd0, 32'h00A5, 3'd0, 8'hA5, 32'h00A5},
      '{1'b1, 3'd1, 32'h000F, 3'd0, 8'hAF, 32'h00AF},
      '{1'b1, 3'd2, 32'h0081, 3'd0, 8'h2E, 32'h002E},
      '{1'b0, 3'd0, 32'h0000, 3'd1, 8'h2E, 32'h0000},
      '{1'b1, 3'd7, 32'h0055, 3'd7, 8'h2E, 32'h0000},
      '{1'b1, 3'd3, 32'hFF1234, 3'd3, 8'h2E, 32'h1234},
      '{1'b1, 3'd3, 32'h0003, 3'd3, 8'h2E, 32'h0003},
      '{1'b1, 3'd0, 32'h0000, 3'd0, 8'h00, 32'h0000},
      '{1'b1, 3'd4, 32'h0001, 3'd5, 8'h01, 32'h0001},
      '{1'b0, 3'd0, 32'h0000, 3'd5, 8'h01, 32'h0001},
      '{1'b0, 3'd0, 32'h0000, 3'd5, 8'h01, 32'h0001},
      '{1'b0, 3'd0, 32'h0000, 3'd5, 8'h00, 32'h0002},
      '{1'b0, 3'd0, 32'h0000, 3'd4, 8'h00, 32'h0001},
      '{1'b1, 3'd5, 32'h0002, 3'd5, 8'h00, 32'h0000},
      '{1'b1, 3'd3, 32'h0000, 3'd3, 8'h00, 32'h0000},
      '{1'b1, 3'd4, 32'h00FF, 3'd5, 8'h00, 32'h0000},
      '{1'b0, 3'd0, 32'h0000, 3'd5, 8'h00, 32'h0000},
      '{1'b1, 3'd3, 32'h0002, 3'd3, 8'h00, 32'h0002},
      '{1'b1, 3'd0, 32'h00F0, 3'd0, 8'hF0, 32'h00F0},
      '{1'b1, 3'd4, 32'h000F, 3'd5, 8'hFF, 32'h0001},
      '{1'b1, 3'd1, 32'h0001, 3'd0, 8'hFE, 32'h00F1},
      '{1'b0, 3'd0, 32'h0000, 3'd5, 8'hF1, 32'h0002},
      '{1'b1, 3'd5, 32'h0002, 3'd5, 8'hF1, 32'h0000},
      '{1'b1, 3'd4, 32'h0000, 3'd5, 8'hF1, 32'h0001},
      '{1'b0, 3'd0, 32'h0000, 3'd5, 8'hF1, 32'h0001},
      '{1'b0, 3'd0, 32'h0000, 3'd5, 8'hF1, 32'h0002},
      '{1'b1, 3'd5, 32'h0002, 3'd5, 8'hF1, 32'h0000},
      '{1'b1, 3'd0, 32'h0000, 3'd0, 8'h00, 32'h0000},
      '{1'b1, 3'd4, 32'h0003, 3'd5, 8'h03, 32'h0001},
      '{1'b1, 3'd3, 32'h0005, 3'd3, 8'h03, 32'h0005},
      '{1'b0, 3'd0, 32'h0000, 3'd5, 8'h00, 32'h0002},
      '{1'b1, 3'd5, 32'h0002, 3'd5, 8'h00, 32'h0000}
    };

    reset_n    = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 3'd0;
    writedata  = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    check("reset out_port", 32'(out_port), 32'h0);
    check("reset readdata", readdata, 32'h0);
    check("reset irq", 32'(irq), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    idle(3'd5, 8'h00, 32'h0, 1'b0, "post-reset status");

    for (int i = 0; i < NVec; i++) begin
      step(vecs[i].we, vecs[i].addr, vecs[i].wd, vecs[i].rd_addr, vecs[i].exp_out,
           vecs[i].exp_rd, 1'b0, $sformatf("vec%0d", i));
    end

    // Restart mid-pulse: bit1 for 5 cycles, then bit2 for 10 more, one DONE.
    step(1'b1, 3'd3, 32'd10, 3'd3, 8'h00, 32'd10, 1'b0, "restart plen");
    step(1'b1, 3'd4, 32'h02, 3'd5, 8'h02, 32'h1, 1'b0, "restart first");
    for (int i = 0; i < 4; i++) idle(3'd5, 8'h02, 32'h1, 1'b0, $sformatf("restart a%0d", i));
    step(1'b1, 3'd4, 32'h04, 3'd5, 8'h04, 32'h1, 1'b0, "restart second");
    for (int i = 0; i < 9; i++) idle(3'd5, 8'h04, 32'h1, 1'b0, $sformatf("restart b%0d", i));
    idle(3'd5, 8'h00, 32'h2, 1'b0, "restart done");
    step(1'b1, 3'd5, 32'h2, 3'd5, 8'h00, 32'h0, 1'b0, "restart clear");
    for (int i = 0; i < 3; i++) idle(3'd5, 8'h00, 32'h0, 1'b0, $sformatf("restart quiet%0d", i));

    // Interrupt enable and W1C clear.
    step(1'b1, 3'd6, 32'h1, 3'd6, 8'h00, 32'(IrqOn), 1'b0, "irqen write");
    step(1'b1, 3'd3, 32'd2, 3'd3, 8'h00, 32'd2, 1'b0, "irq plen");
    step(1'b1, 3'd4, 32'h01, 3'd5, 8'h01, 32'h1, 1'b0, "irq pulse");
    idle(3'd5, 8'h01, 32'h1, 1'b0, "irq busy");
    idle(3'd5, 8'h00, 32'h2, IrqOn, "irq raised");
    step(1'b1, 3'd5, 32'h2, 3'd5, 8'h00, 32'h0, 1'b0, "irq cleared");

    // DONE set by hardware in the same cycle software clears it: set wins.
    step(1'b1, 3'd3, 32'd1, 3'd3, 8'h00, 32'd1, 1'b0, "setwins plen");
    step(1'b1, 3'd4, 32'h01, 3'd5, 8'h01, 32'h1, 1'b0, "setwins pulse");
    step(1'b1, 3'd5, 32'h2, 3'd5, 8'h00, 32'h2, IrqOn, "setwins collide");

    // Long pulse aborted by reset at cycle 20.
    step(1'b1, 3'd3, 32'd100, 3'd3, 8'h00, 32'd100, IrqOn, "abort plen");
    step(1'b1, 3'd4, 32'hFF, 3'd5, 8'hFF, 32'h3, IrqOn, "abort pulse");
    for (int i = 0; i < 19; i++) idle(3'd5, 8'hFF, 32'h3, IrqOn, $sformatf("abort run%0d", i));
    #1;
    reset_n = 1'b0;
    #1;
    e.out = '0;
    e.rd  = 32'h0;
    e.irq = 1'b0;
    sb_q.push_back(e);
    compare("abort in reset");
    address = 3'd3;
    #1;
    check("abort plen cleared", readdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 110; i++) idle(3'd5, 8'h00, 32'h0, 1'b0, $sformatf("after abort%0d", i));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
